// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU completion requests toward the arbiter and the registered CDB broadcast back.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int ORDER_W = 64,
  parameter int FU_ID_W = $clog2(NUM_REQ)
);
  logic                       flush;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*5-1:0]       req_rd;
  logic [NUM_REQ*32-1:0]      req_data;
  logic [NUM_REQ*ORDER_W-1:0] req_order;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       cdb_valid;
  logic [FU_ID_W-1:0]         cdb_fu_id;
  logic [4:0]                 cdb_rd;
  logic [31:0]                cdb_data;
  logic                       starve_pulse;
  modport master (
    output flush, req_valid, req_rd, req_data, req_order,
    input  req_ready, cdb_valid, cdb_fu_id, cdb_rd, cdb_data, starve_pulse
  );
  modport slave (
    input  flush, req_valid, req_rd, req_data, req_order,
    output req_ready, cdb_valid, cdb_fu_id, cdb_rd, cdb_data, starve_pulse
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: oldest-first CDB arbiter with an aging override that bounds how long any FU can lose.
module cdb_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int ORDER_W  = 64,
  parameter int MAX_WAIT = 4
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int FU_ID_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_WAIT + 1);
  logic [NUM_REQ-1:0][CNT_W-1:0] r_wait_cnt;
  logic                          r_cdb_valid;
  logic                          r_starve;
  logic [FU_ID_W-1:0]            r_fu_id;
  logic [4:0]                    r_rd;
  logic [31:0]                   r_data;
  logic                          w_age_hit;
  logic [FU_ID_W-1:0]            w_age_idx;
  logic                          w_old_hit;
  logic [FU_ID_W-1:0]            w_old_idx;
  logic [ORDER_W-1:0]            w_old_tag;
  logic                          w_gnt;
  logic [FU_ID_W-1:0]            w_gnt_idx;
  logic [NUM_REQ-1:0]            w_ready;
  // Descending scan leaves the lowest aged index; strict < keeps the lowest index on equal tags.
  always_comb begin
    w_age_hit = 1'b0;
    w_age_idx = '0;
    w_old_hit = 1'b0;
    w_old_idx = '0;
    w_old_tag = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && r_wait_cnt[i] == CNT_W'(MAX_WAIT)) begin
        w_age_hit = 1'b1;
        w_age_idx = FU_ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && (!w_old_hit || bus.req_order[i*ORDER_W +: ORDER_W] < w_old_tag)) begin
        w_old_hit = 1'b1;
        w_old_idx = FU_ID_W'(i);
        w_old_tag = bus.req_order[i*ORDER_W +: ORDER_W];
      end
    end
  end
  assign w_gnt     = !rst && !bus.flush && (w_age_hit || w_old_hit);
  assign w_gnt_idx = w_age_hit ? w_age_idx : w_old_idx;
  always_comb begin
    w_ready = '0;
    if (w_gnt) w_ready[w_gnt_idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_starve    <= 1'b0;
      r_fu_id     <= '0;
      r_rd        <= '0;
      r_data      <= '0;
    end else begin
      r_cdb_valid <= w_gnt;
      r_starve    <= w_gnt && w_age_hit;
      if (w_gnt) begin
        r_fu_id <= w_gnt_idx;
        r_rd    <= bus.req_rd[w_gnt_idx*5 +: 5];
        r_data  <= bus.req_data[w_gnt_idx*32 +: 32];
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || bus.flush || !bus.req_valid[i] || w_ready[i])
        r_wait_cnt[i] <= '0;
      else if (r_wait_cnt[i] != CNT_W'(MAX_WAIT))
        r_wait_cnt[i] <= r_wait_cnt[i] + CNT_W'(1);
    end
  end
  assign bus.req_ready    = w_ready;
  assign bus.cdb_valid    = r_cdb_valid;
  assign bus.cdb_fu_id    = r_fu_id;
  assign bus.cdb_rd       = r_rd;
  assign bus.cdb_data     = r_data;
  assign bus.starve_pulse = r_starve;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a grant/broadcast scoreboard checked by an independent monitor.
module tb_cdb_arbiter;
  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        st;
  } bc_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mon_en = 1'b0;
  logic [7:0]  v_a;
  logic [4:0]  rd_a  [8];
  logic [31:0] dat_a [8];
  logic [63:0] ord_a [8];
  bc_t         cq[$];
  logic [7:0]  rq[$];
  bc_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  cdb_arbiter_if #(.NUM_REQ(8), .ORDER_W(64)) bus ();
  cdb_arbiter #(.NUM_REQ(8), .ORDER_W(64), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.flush     = flush;
    bus.req_valid = v_a;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.req_order = '0;
    for (int i = 0; i < 8; i++) begin
      bus.req_rd[i*5 +: 5]     = rd_a[i];
      bus.req_data[i*32 +: 32] = dat_a[i];
      bus.req_order[i*64 +: 64] = ord_a[i];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic req(input int i, input logic [4:0] r, input logic [31:0] d, input logic [63:0] o);
    v_a[i]   = 1'b1;
    rd_a[i]  = r;
    dat_a[i] = d;
    ord_a[i] = o;
  endtask
  task automatic tick(input logic [7:0] er, input bit bc, input int g, input bit st);
    rq.push_back(er);
    if (bc) cq.push_back('{3'(g), rd_a[g], dat_a[g], st});
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
    chk({nm, "_starve"}, 64'(bus.starve_pulse), 64'd0);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (rq.size() > 0) chk("req_ready", 64'(bus.req_ready), 64'(rq.pop_front()));
      if (bus.cdb_valid) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cdb_extra: got fu_id %0d with no broadcast expected at %0t", bus.cdb_fu_id, $time);
        end else begin
          mon_e = cq.pop_front();
          chk("cdb_fu_id", 64'(bus.cdb_fu_id), 64'(mon_e.id));
          chk("cdb_rd", 64'(bus.cdb_rd), 64'(mon_e.rd));
          chk("cdb_data", 64'(bus.cdb_data), 64'(mon_e.d));
          chk("starve_pulse", 64'(bus.starve_pulse), 64'(mon_e.st));
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    v_a = '0;
    for (int i = 0; i < 8; i++) begin
      rd_a[i] = '0;
      dat_a[i] = '0;
      ord_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_fu_id", 64'(bus.cdb_fu_id), 64'd0);
    chk("reset_rd", 64'(bus.cdb_rd), 64'd0);
    chk("reset_data", 64'(bus.cdb_data), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    // single request on an idle bus
    req(3, 5'd5, 32'hDEADBEEF, 64'd10);
    tick(8'h08, 1, 3, 0);
    v_a[3] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // oldest-first ordering
    req(1, 5'd11, 32'h1111_0001, 64'd20);
    req(6, 5'd16, 32'h6666_0006, 64'd7);
    req(2, 5'd12, 32'h2222_0002, 64'd15);
    tick(8'h40, 1, 6, 0);
    v_a[6] = 1'b0;
    tick(8'h04, 1, 2, 0);
    v_a[2] = 1'b0;
    tick(8'h02, 1, 1, 0);
    v_a[1] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // aging override: FU7 loses four times then is forced through
    req(7, 5'd17, 32'h7777_0007, 64'd100);
    for (int k = 1; k <= 4; k++) begin
      req(0, 5'd1, 32'h0000_0100 + 32'(k), 64'(k));
      tick(8'h01, 1, 0, 0);
    end
    req(0, 5'd1, 32'h0000_0105, 64'd5);
    tick(8'h80, 1, 7, 1);
    chk("fu7_wait_cleared", 64'(dut.r_wait_cnt[7]), 64'd0);
    v_a[7] = 1'b0;
    tick(8'h01, 1, 0, 0);
    v_a[0] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // flush blocks the grant and clears the counters
    req(0, 5'd2, 32'h0000_00F0, 64'd50);
    req(4, 5'd14, 32'h4444_0004, 64'd40);
    flush = 1'b1;
    tick(8'h00, 0, 0, 0);
    flush = 1'b0;
    chk_idle("flush");
    for (int i = 0; i < 8; i++) chk("flush_wait_cnt", 64'(dut.r_wait_cnt[i]), 64'd0);
    tick(8'h10, 1, 4, 0);
    v_a[4] = 1'b0;
    tick(8'h01, 1, 0, 0);
    v_a[0] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // rd=0 still occupies the slot
    req(5, 5'd0, 32'h0000_0001, 64'd60);
    tick(8'h20, 1, 5, 0);
    v_a[5] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // equal tags resolve to the lowest index
    req(3, 5'd3, 32'h3333_0003, 64'd90);
    req(5, 5'd5, 32'h5555_0005, 64'd90);
    tick(8'h08, 1, 3, 0);
    v_a[3] = 1'b0;
    tick(8'h20, 1, 5, 0);
    v_a[5] = 1'b0;
    // back-to-back requests from the same FU
    req(1, 5'd21, 32'hB2B0_0001, 64'd80);
    tick(8'h02, 1, 1, 0);
    req(1, 5'd22, 32'hB2B0_0002, 64'd81);
    tick(8'h02, 1, 1, 0);
    v_a[1] = 1'b0;
    tick(8'h00, 0, 0, 0);
    // reset in the middle of a broadcast
    req(2, 5'd9, 32'hCAFE_F00D, 64'd70);
    tick(8'h04, 1, 2, 0);
    rst = 1'b1;
    tick(8'h00, 0, 0, 0);
    chk_idle("rst_mid");
    chk("rst_mid_fu_id", 64'(bus.cdb_fu_id), 64'd0);
    chk("rst_mid_rd", 64'(bus.cdb_rd), 64'd0);
    chk("rst_mid_data", 64'(bus.cdb_data), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
    v_a[2] = 1'b0;
    rst = 1'b0;
    tick(8'h00, 0, 0, 0);
    tick(8'h00, 0, 0, 0);
    chk("pending_broadcasts", 64'(cq.size()), 64'd0);
    chk("pending_ready", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Single-port Common Data Bus arbiter between the functional units and the scoreboard/register file write port. Each FU presents a completed result (fu_id implicit by port index, rd, data, program order tag). The arbiter grants one FU per cycle and drives a registered CDB broadcast. Policy is oldest-first by order tag, with an aging override that bounds wait time for any requester.

Parameters:
NUM_REQ, 8, number of requesting FUs; port index equals fu_id.
ORDER_W, 64, width of the program-order tag; tags are monotonic and never wrap.
MAX_WAIT, 4, cycles a pending request may lose before it is forced to win; must be >= 1.
FU_ID_W, $clog2(NUM_REQ), width of the fu_id field.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
flush  in  1  global flush (branch mispredict).
req_valid  in  NUM_REQ  per-FU completion request.
req_rd  in  NUM_REQ*5  per-FU destination register (flattened, FU i at [5i+4:5i]).
req_data  in  NUM_REQ*32  per-FU result.
req_order  in  NUM_REQ*ORDER_W  per-FU instruction order tag.
req_ready  out  NUM_REQ  one-hot grant; FU retires its result on req_valid & req_ready.
cdb_valid  out  1  registered broadcast valid.
cdb_fu_id  out  FU_ID_W  index of the producing FU.
cdb_rd  out  5  destination register.
cdb_data  out  32  result value.
starve_pulse  out  1  registered; 1 for one cycle when the previous grant was made by the aging override.

Behaviour:
- Handshake:
  - FU holds req_valid, rd, data and order stable until it sees req_ready high in the same cycle.
  - req_ready is combinational and at most one bit is high.
  - req_ready is all-zero while rst or flush is high.
- Grant selection (combinational):
  - Aging override: if any valid requester has wait_cnt[i] == MAX_WAIT, the lowest such index wins.
  - Otherwise the valid requester with the smallest req_order wins. Equal tags, which are illegal, resolve to the lowest index.
  - No valid requests means no grant.
- Requests with rd == 0 are granted and broadcast normally; they still occupy the slot.
- CDB register: latency 1.
  - On a grant to FU g, the next cycle shows cdb_valid=1, cdb_fu_id=g, cdb_rd=req_rd[g], cdb_data=req_data[g].
  - A cycle with no grant gives cdb_valid=0 on the next cycle.
  - fu_id/rd/data hold their last value when invalid.
- Wait counters, one per requester, saturating at MAX_WAIT:
  - req_valid & !req_ready: increment.
  - Granted, or !req_valid: clear to 0.
- starve_pulse is registered alongside cdb_valid. It is 1 iff the grant that produced this broadcast came from the aging override.
- Flush:
  - No grant in the flush cycle.
  - Next cycle: cdb_valid=0, starve_pulse=0, all wait_cnt=0.
  - A grant made in the cycle before flush still broadcasts in the flush cycle; downstream discards it.
- Reset: cdb_valid=0, cdb_fu_id=0, cdb_rd=0, cdb_data=0, starve_pulse=0, all wait_cnt=0. Reset in mid-broadcast drops it.
- Back-to-back: a requester granted in cycle N may request again in N+1 and is eligible immediately.

Test Plan:
1. Single request, idle bus: FU3 asserts req_valid, rd=5, data=0xDEADBEEF, order=10 -> req_ready[3]=1 same cycle; next cycle cdb_valid=1, fu_id=3, rd=5, data=0xDEADBEEF.
2. Oldest-first: FU1 order=20, FU6 order=7, FU2 order=15, all valid -> grants in order FU6, FU2, FU1 on consecutive cycles; cdb shows fu_id 6, 2, 1.
3. Aging override (MAX_WAIT=4): FU7 holds order=100 while FU0 issues a fresh request with order 1, 2, 3, ... every cycle -> FU7 loses 4 times, then wins on cycle 5; starve_pulse=1 with that broadcast; FU7 wait_cnt clears.
4. Flush: FU0 and FU4 valid, flush high for 1 cycle -> req_ready=0 in that cycle; next cycle cdb_valid=0 and counters are 0; FU4 (older) is granted the cycle after flush drops.
5. Reset mid-traffic: grant to FU2 in cycle N, rst=1 in cycle N+1 -> cdb_valid=0 and all outputs 0 in cycle N+2; no req_ready during rst.
6. rd=0 result: FU5 rd=0, data=0x1 -> granted and broadcast with cdb_rd=0, cdb_valid=1.
